ps2_key_decoder: RTL
====================

Name: ps2_key_decoder

Overview:
- Sits between the PS/2 byte receiver and the scan-code-to-ASCII lookup stage.
- Pops raw bytes from the receiver through its ready/nextdata_n handshake.
- Strips the F0 (break) and E0 (extended) prefixes and tracks Shift and Caps Lock state.
- Filters typematic repeats, so each physical keypress produces exactly one registered scan code, one shift level and a one-cycle key_valid pulse for the lookup stage.
- Also keeps a running press count for seven-segment display.

Parameters:
- SHIFT_L, 8'h12, left Shift make code
- SHIFT_R, 8'h59, right Shift make code
- CAPS, 8'h58, Caps Lock make code
- CNT_W, 8, width of key_count

Ports:
- clk  in  1  system clock, all logic on rising edge
- clrn  in  1  asynchronous active-low reset
- ps2_data  in  8  byte at the head of the receiver FIFO
- ps2_ready  in  1  receiver FIFO non-empty
- ps2_nextdata_n  out  1  active-low pop strobe to the receiver, one cycle wide
- scan_code  out  8  make code of the most recent accepted key, held until the next accepted key
- shift  out  1  left Shift or right Shift currently held
- caps  out  1  Caps Lock toggle state
- key_down  out  1  the key in scan_code is currently held
- key_valid  out  1  one-cycle pulse: new key accepted, scan_code updated in the same cycle
- key_count  out  CNT_W  number of accepted keys, wraps

Behaviour:
- Reset (clrn=0, asynchronous) forces:
  - scan_code=0, shift=0 (both shift bits clear), caps=0, key_down=0, key_valid=0, key_count=0.
  - ps2_nextdata_n=1.
  - brk=0, ext=0, caps_held=0, FSM=IDLE.
- Reset asserted mid-sequence discards any pending prefix. A byte not yet popped stays in the receiver.
- Handshake FSM:
  - IDLE: if ps2_ready=1, latch ps2_data into the decode logic, drive ps2_nextdata_n=0 for that cycle, go to GAP.
  - GAP: ps2_nextdata_n=1. Unconditionally return to IDLE next cycle. This gap lets the receiver update ps2_ready.
  - Maximum throughput is one byte per 2 cycles. Exactly one pop is issued per byte.
- Decoding happens on the IDLE cycle that pops the byte. Register updates are visible on the following cycle. Precedence:
  1. Byte 8'hE0: set ext=1. No other effect.
  2. Byte 8'hF0: set brk=1. ext is kept.
  3. brk=1 (release):
     - If ext=0 and the code is SHIFT_L or SHIFT_R, clear that shift bit.
     - If ext=0 and the code is CAPS, clear caps_held.
     - If the code equals scan_code and ext=0, clear key_down.
     - Then clear brk and ext.
  4. brk=0, ext=1 (extended make): ignored, no pulse. Clear ext. An extended release (E0 F0 xx) never touches the shift bits.
  5. Make of SHIFT_L or SHIFT_R: set that shift bit. No key_valid, scan_code unchanged.
  6. Make of CAPS: if caps_held=0, toggle caps and set caps_held. If caps_held=1 (typematic repeat), no change. No key_valid.
  7. Make with key_down=1 and code==scan_code: typematic repeat, ignored.
  8. Any other make:
     - scan_code<=code, key_down<=1, key_valid<=1 for exactly one cycle.
     - key_count<=key_count+1, wrapping from all-ones to 0.
- shift output = OR of the two shift bits. Releasing one Shift while the other is held keeps shift=1.
- Pressing a new key while another is held replaces scan_code. The earlier key's later release does not clear key_down because its code no longer matches scan_code.
- key_valid is never asserted on the GAP cycle. It cannot occur on two consecutive cycles.
- Unknown codes (the lookup stage maps these to FF) are still accepted and counted. Filtering them is the downstream stage's job.

Test Plan:
- Reset, then bytes 1C, F0, 1C → one key_valid pulse with scan_code=1C, shift=0, key_count=1; key_down=1 until F0 1C, then key_down=0; exactly 3 ps2_nextdata_n pulses.
- Bytes 12, 1C, 1C, 1C, F0, 1C, F0, 12 → single key_valid with scan_code=1C and shift=1; repeats produce no pulses; shift=0 after F0 12; key_count=1.
- Bytes 12, 59, F0, 12 → shift stays 1; then F0, 59 → shift=0; no key_valid throughout.
- Bytes 58, 58, F0, 58, 58, F0, 58 → caps goes 0→1 (second 58 ignored), then 1→0 on the next press.
- Bytes E0, 75, E0, F0, 75, E0, F0, 12 with Shift held → no key_valid and shift stays 1; next 16 decodes normally to scan_code=16.
- Preload key_count=FF via 255 distinct presses, press 2D → key_count=00. Assert clrn low between F0 and its code → all outputs 0; the next byte 1C is treated as a make.

Source files
------------

// File: rtl/ps2_key_decoder.sv
// PS/2 scan-code decoder: pops raw bytes from the receiver, strips the
// E0/F0 prefixes, tracks Shift/Caps Lock and filters typematic repeats so
// every physical keypress yields one key_valid pulse for the lookup stage.
module ps2_key_decoder #(
  parameter logic [7:0] SHIFT_L = 8'h12,
  parameter logic [7:0] SHIFT_R = 8'h59,
  parameter logic [7:0] CAPS    = 8'h58,
  parameter int         CNT_W   = 8
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic [7:0]       ps2_data,
  input  logic             ps2_ready,
  output logic             ps2_nextdata_n,
  output logic [7:0]       scan_code,
  output logic             shift,
  output logic             caps,
  output logic             key_down,
  output logic             key_valid,
  output logic [CNT_W-1:0] key_count
);

  typedef enum logic {IDLE = 1'b0, GAP = 1'b1} state_t;

  localparam logic [7:0] CODE_EXT = 8'hE0;
  localparam logic [7:0] CODE_BRK = 8'hF0;

  state_t             state_reg, state_next;
  logic               pop;
  logic [7:0]         scan_code_reg, scan_code_next;
  logic [1:0]         shift_reg, shift_next;
  logic               caps_reg, caps_next;
  logic               caps_held_reg, caps_held_next;
  logic               key_down_reg, key_down_next;
  logic               key_valid_reg, key_valid_next;
  logic [CNT_W-1:0]   key_count_reg, key_count_next;
  logic               brk_reg, brk_next;
  logic               ext_reg, ext_next;

  // Bit 0 tracks left Shift, bit 1 tracks right Shift.
  logic [1:0][7:0]    shift_codes;
  logic [1:0]         shift_hit;

  assign shift_codes[0] = SHIFT_L;
  assign shift_codes[1] = SHIFT_R;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_shift_hit
      assign shift_hit[gi] = (ps2_data == shift_codes[gi]);
    end
  endgenerate

  // A byte is consumed on every IDLE cycle that finds the receiver non-empty.
  // The strobe is suppressed while reset is held so no byte is lost.
  assign pop            = (state_reg == IDLE) && ps2_ready;
  assign ps2_nextdata_n = ~(pop & clrn);

  assign scan_code = scan_code_reg;
  assign shift     = |shift_reg;
  assign caps      = caps_reg;
  assign key_down  = key_down_reg;
  assign key_valid = key_valid_reg;
  assign key_count = key_count_reg;

  // State register and all decode state.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_reg     <= IDLE;
      scan_code_reg <= '0;
      shift_reg     <= '0;
      caps_reg      <= 1'b0;
      caps_held_reg <= 1'b0;
      key_down_reg  <= 1'b0;
      key_valid_reg <= 1'b0;
      key_count_reg <= '0;
      brk_reg       <= 1'b0;
      ext_reg       <= 1'b0;
    end else begin
      state_reg     <= state_next;
      scan_code_reg <= scan_code_next;
      shift_reg     <= shift_next;
      caps_reg      <= caps_next;
      caps_held_reg <= caps_held_next;
      key_down_reg  <= key_down_next;
      key_valid_reg <= key_valid_next;
      key_count_reg <= key_count_next;
      brk_reg       <= brk_next;
      ext_reg       <= ext_next;
    end
  end

  // Handshake sequencing plus decode of the byte popped this cycle.
  always_comb begin
    state_next     = state_reg;
    scan_code_next = scan_code_reg;
    shift_next     = shift_reg;
    caps_next      = caps_reg;
    caps_held_next = caps_held_reg;
    key_down_next  = key_down_reg;
    key_valid_next = 1'b0;
    key_count_next = key_count_reg;
    brk_next       = brk_reg;
    ext_next       = ext_reg;

    case (state_reg)
      IDLE: if (pop) state_next = GAP;
      GAP:  state_next = IDLE;
      default: state_next = IDLE;
    endcase

    if (pop) begin
      if (ps2_data == CODE_EXT) begin
        ext_next = 1'b1;
      end else if (ps2_data == CODE_BRK) begin
        brk_next = 1'b1;
      end else if (brk_reg) begin
        // Release: extended releases never touch modifiers or key_down.
        if (!ext_reg) begin
          for (int i = 0; i < 2; i++) begin
            if (shift_hit[i]) shift_next[i] = 1'b0;
          end
          if (ps2_data == CAPS)          caps_held_next = 1'b0;
          if (ps2_data == scan_code_reg) key_down_next  = 1'b0;
        end
        brk_next = 1'b0;
        ext_next = 1'b0;
      end else if (ext_reg) begin
        ext_next = 1'b0;
      end else if (|shift_hit) begin
        shift_next = shift_reg | shift_hit;
      end else if (ps2_data == CAPS) begin
        // Only the first make toggles; typematic repeats wait for release.
        if (!caps_held_reg) begin
          caps_next      = ~caps_reg;
          caps_held_next = 1'b1;
        end
      end else if (key_down_reg && (ps2_data == scan_code_reg)) begin
        // Typematic repeat of the held key: nothing to report.
      end else begin
        scan_code_next = ps2_data;
        key_down_next  = 1'b1;
        key_valid_next = 1'b1;
        key_count_next = key_count_reg + CNT_W'(1);
      end
    end
  end

endmodule
